// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer slice.
//   ALU_DW        : width of the companion combinational ALU
//   OPW           : ALU opcode width
//   OP_*          : ALU opcode encodings
//   state_e       : sequencer FSM states
//   is_zero()     : zero-flag helper for results
package alu_cmd_sequencer_pkg;

  localparam int ALU_DW = 8;
  localparam int OPW    = 3;

  localparam logic [OPW-1:0] OP_NOT  = 3'b000;
  localparam logic [OPW-1:0] OP_OR   = 3'b001;
  localparam logic [OPW-1:0] OP_XOR  = 3'b010;
  localparam logic [OPW-1:0] OP_AND  = 3'b011;
  localparam logic [OPW-1:0] OP_MULN = 3'b100;
  localparam logic [OPW-1:0] OP_ADD  = 3'b101;
  localparam logic [OPW-1:0] OP_SUB  = 3'b110;
  localparam logic [OPW-1:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  function automatic logic is_zero(input logic [ALU_DW-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle for the ALU command sequencer.
//   cmd_* : command channel (valid/ready), master -> sequencer
//   res_* : result channel (valid/ready), sequencer -> master
// modport master : command producer / result consumer
// modport slave  : the sequencer
interface alu_cmd_sequencer_if
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 2
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_load;
  logic [OPW-1:0] cmd_op;
  logic [AW-1:0]  cmd_dst;
  logic [AW-1:0]  cmd_src_a;
  logic [AW-1:0]  cmd_src_b;
  logic           cmd_imm_en;
  logic [DW-1:0]  cmd_imm;

  logic           res_valid;
  logic           res_ready;
  logic [DW-1:0]  res_data;
  logic [AW-1:0]  res_dst;
  logic           res_zero;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b,
           cmd_imm_en, cmd_imm, res_ready,
    input  cmd_ready, res_valid, res_data, res_dst, res_zero
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_src_a, cmd_src_b,
           cmd_imm_en, cmd_imm, res_ready,
    output cmd_ready, res_valid, res_data, res_dst, res_zero
  );

endinterface

// File: rtl/alu_cmd_sequencer_regfile.sv
// Operand register file for the ALU command sequencer.
//   clk, rst_n          : clock, async active-low reset (clears all entries)
//   we, waddr, wdata    : single write port
//   ra_addr / ra_data   : operand A read (combinational)
//   rb_addr / rb_data   : operand B read (combinational)
//   rd_addr / rd_data   : debug read (combinational)
module alu_cmd_sequencer_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
  assign rd_data = regs[rd_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Control stage in front of an 8-bit combinational ALU.
//   clk, rst_n        : clock, async active-low reset
//   bus (slave)       : command and result handshakes
//   alu_a/alu_b/alu_op: registered operands and opcode to the ALU
//   alu_out           : ALU result, sampled only in EXEC
//   rd_addr/rd_data   : debug read of the register file
//   op_count          : completed results, wraps modulo 2^CW
// A load writes its immediate and goes straight to WB; an ALU command
// registers its operands, samples the ALU one cycle later in EXEC, writes
// back, then waits in WB until the result is taken.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int CW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   bus,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [OPW-1:0]       alu_op,
  input  logic [DW-1:0]        alu_out,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic [CW-1:0]        op_count
);

  state_e        state_q, state_d;
  logic          accept;
  logic          done;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] dst_q;
  logic [DW-1:0] ra_data, rb_data;

  alu_cmd_sequencer_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .ra_addr (bus.cmd_src_a),
    .ra_data (ra_data),
    .rb_addr (bus.cmd_src_b),
    .rb_data (rb_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Gated by rst_n so no command appears acceptable while reset is held.
  assign bus.cmd_ready = (state_q == IDLE) && rst_n;
  assign bus.res_valid = (state_q == WB);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign done          = bus.res_valid && bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    waddr   = bus.cmd_dst;
    wdata   = bus.cmd_imm;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_load) begin
            we      = 1'b1;
            state_d = WB;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        we      = 1'b1;
        waddr   = dst_q;
        wdata   = alu_out;
        state_d = WB;
      end
      WB: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      dst_q        <= '0;
      bus.res_data <= '0;
      bus.res_dst  <= '0;
      bus.res_zero <= 1'b0;
      op_count     <= '0;
    end else begin
      if (accept && !bus.cmd_load) begin
        alu_a  <= ra_data;
        alu_b  <= bus.cmd_imm_en ? bus.cmd_imm : rb_data;
        alu_op <= bus.cmd_op;
        dst_q  <= bus.cmd_dst;
      end
      // Result fields track every write-back and stay frozen through WB.
      if (we) begin
        bus.res_data <= wdata;
        bus.res_dst  <= waddr;
        bus.res_zero <= is_zero(wdata);
      end
      if (done) op_count <= op_count + 1'b1;
    end
  end

endmodule
